// File: rtl/mem_stage_logic_pkg.sv
// Shared types for the MEM stage: word/mask types, FSM state encoding, alignment helper.
package mem_stage_logic_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        MEM_IDLE   = 2'd0,
        MEM_IND_RD = 2'd1,
        MEM_ACCESS = 2'd2,
        MEM_DONE   = 2'd3
    } lc3b_mem_state;

    // Word accesses ignore address bit 0; odd word addresses are silently aligned down.
    function automatic lc3b_word word_align(input lc3b_word addr);
        return {addr[15:1], 1'b0};
    endfunction

endpackage

// File: rtl/mem_byte_align.sv
// Byte-lane steering for the MEM stage: load lane select with zero-extension,
// store data replication and write lane mask.
module mem_byte_align
    import mem_stage_logic_pkg::*;
(
    input  logic          byte_op,
    input  logic          addr_lsb,
    input  lc3b_word      rdata,
    input  lc3b_word      sdata,
    output lc3b_word      load_data,
    output lc3b_word      store_data,
    output lc3b_mem_wmask byte_enable
);

    // Select the load lane and build the store lane pattern from the registered access flags.
    always_comb begin
        load_data   = rdata;
        store_data  = sdata;
        byte_enable = 2'b11;
        if (byte_op) begin
            load_data   = addr_lsb ? {8'h00, rdata[15:8]} : {8'h00, rdata[7:0]};
            store_data  = {sdata[7:0], sdata[7:0]};
            byte_enable = addr_lsb ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_stage_logic.sv
// MEM stage: runs one data-memory transaction per load/store (two for indirect ops)
// over a level req / pulse resp handshake and stalls the pipe until it completes.
module mem_stage_logic
    import mem_stage_logic_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  lc3b_word      mem_addr_in,
    input  lc3b_word      mem_sdata_in,
    input  logic          mem_read_op,
    input  logic          mem_write_op,
    input  logic          mem_byte_op,
    input  logic          mem_indirect_op,
    input  logic          pipe_advance,
    input  lc3b_word      dmem_rdata,
    input  logic          dmem_resp,
    output logic          dmem_read,
    output logic          dmem_write,
    output lc3b_word      dmem_addr,
    output lc3b_word      dmem_wdata,
    output lc3b_mem_wmask dmem_byte_enable,
    output lc3b_word      mem_rdata_out,
    output logic          mem_stall
);

    lc3b_mem_state state, state_n;
    lc3b_word      addr_r, data_r, rdata_r;
    logic          rd_r, wr_r, byte_r, ind_r;
    logic          op;

    lc3b_word      load_data, store_data;
    lc3b_mem_wmask lane_mask;

    // A simultaneous read/write decode is resolved as a write.
    assign op = mem_read_op | mem_write_op;

    mem_byte_align u_align (
        .byte_op     (byte_r),
        .addr_lsb    (addr_r[0]),
        .rdata       (dmem_rdata),
        .sdata       (data_r),
        .load_data   (load_data),
        .store_data  (store_data),
        .byte_enable (lane_mask)
    );

    // State register plus the address/data/result latches of the current access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= MEM_IDLE;
            addr_r  <= '0;
            data_r  <= '0;
            rdata_r <= '0;
            rd_r    <= 1'b0;
            wr_r    <= 1'b0;
            byte_r  <= 1'b0;
            ind_r   <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                MEM_IDLE: begin
                    if (op) begin
                        addr_r  <= mem_addr_in;
                        data_r  <= mem_sdata_in;
                        rdata_r <= '0;
                        rd_r    <= mem_read_op & ~mem_write_op;
                        wr_r    <= mem_write_op;
                        byte_r  <= mem_byte_op;
                        ind_r   <= mem_indirect_op;
                    end
                end
                MEM_IND_RD: begin
                    if (dmem_resp) addr_r <= dmem_rdata;
                end
                MEM_ACCESS: begin
                    if (dmem_resp && rd_r) rdata_r <= load_data;
                end
                default: ;
            endcase
        end
    end

    // Next state and all outputs; requests depend only on registered state.
    always_comb begin
        state_n          = state;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_addr        = '0;
        dmem_wdata       = '0;
        dmem_byte_enable = '0;
        mem_rdata_out    = '0;
        mem_stall        = 1'b0;
        case (state)
            MEM_IDLE: begin
                mem_stall = op & ~reset;
                if (op) state_n = mem_indirect_op ? MEM_IND_RD : MEM_ACCESS;
            end
            MEM_IND_RD: begin
                dmem_read = 1'b1;
                dmem_addr = word_align(addr_r);
                mem_stall = 1'b1;
                if (dmem_resp) state_n = MEM_ACCESS;
            end
            MEM_ACCESS: begin
                dmem_read  = ~wr_r;
                dmem_write = wr_r;
                dmem_addr  = byte_r ? addr_r : word_align(addr_r);
                if (wr_r) begin
                    dmem_wdata       = store_data;
                    dmem_byte_enable = lane_mask;
                end
                mem_stall = 1'b1;
                if (dmem_resp) state_n = MEM_DONE;
            end
            MEM_DONE: begin
                mem_rdata_out = rdata_r;
                if (pipe_advance) state_n = MEM_IDLE;
            end
            default: state_n = MEM_IDLE;
        endcase
    end

    // ind_r is kept for observability of the latched decode; it does not steer the FSM after IDLE.
    logic unused_ok;
    assign unused_ok = ind_r;

endmodule

// File: tb/tb_mem_stage_logic.sv
// Directed self-checking bench for mem_stage_logic.
module tb_mem_stage_logic;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_addr_in, mem_sdata_in, dmem_rdata;
    logic        mem_read_op, mem_write_op, mem_byte_op, mem_indirect_op;
    logic        pipe_advance, dmem_resp;
    logic        dmem_read, dmem_write, mem_stall;
    logic [15:0] dmem_addr, dmem_wdata, mem_rdata_out;
    logic [1:0]  dmem_byte_enable;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage_logic dut (
        .clk              (clk),
        .reset            (reset),
        .mem_addr_in      (mem_addr_in),
        .mem_sdata_in     (mem_sdata_in),
        .mem_read_op      (mem_read_op),
        .mem_write_op     (mem_write_op),
        .mem_byte_op      (mem_byte_op),
        .mem_indirect_op  (mem_indirect_op),
        .pipe_advance     (pipe_advance),
        .dmem_rdata       (dmem_rdata),
        .dmem_resp        (dmem_resp),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .mem_rdata_out    (mem_rdata_out),
        .mem_stall        (mem_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] d,
                         input logic rd, input logic wr, input logic by, input logic ind);
        mem_addr_in = a; mem_sdata_in = d;
        mem_read_op = rd; mem_write_op = wr; mem_byte_op = by; mem_indirect_op = ind;
        #1;
    endtask

    task automatic clear_ops();
        mem_read_op = 0; mem_write_op = 0; mem_byte_op = 0; mem_indirect_op = 0;
        mem_addr_in = 16'h0; mem_sdata_in = 16'h0;
    endtask

    task automatic respond(input logic [15:0] d);
        dmem_rdata = d; dmem_resp = 1'b1;
        step();
        dmem_resp = 1'b0; dmem_rdata = 16'h0;
        #1;
    endtask

    task automatic advance();
        pipe_advance = 1'b1;
        step();
        pipe_advance = 1'b0;
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_rd"},    dmem_read, 0);
        chk({tag, "_wr"},    dmem_write, 0);
        chk({tag, "_addr"},  dmem_addr, 0);
        chk({tag, "_wdata"}, dmem_wdata, 0);
        chk({tag, "_be"},    dmem_byte_enable, 0);
        chk({tag, "_out"},   mem_rdata_out, 0);
        chk({tag, "_stall"}, mem_stall, 0);
    endtask

    initial begin
        reset = 1; pipe_advance = 0; dmem_resp = 0; dmem_rdata = 0;
        clear_ops();
        step(); step();
        chk_quiet("rst");
        reset = 0;
        #1;

        // 1: LDR 0x1004, two wait cycles, data 0xBEEF -> 4 stall cycles
        issue(16'h1004, 16'h0, 1, 0, 0, 0);
        chk("ldr_idle_stall", mem_stall, 1);
        chk("ldr_idle_noreq", dmem_read, 0);
        step(); clear_ops(); #1;
        chk("ldr_acc1_rd", dmem_read, 1);
        chk("ldr_acc1_addr", dmem_addr, 16'h1004);
        chk("ldr_acc1_stall", mem_stall, 1);
        step();
        chk("ldr_acc2_rd", dmem_read, 1);
        step();
        chk("ldr_acc3_rd", dmem_read, 1);
        chk("ldr_acc3_stall", mem_stall, 1);
        respond(16'hBEEF);
        chk("ldr_done_rd", dmem_read, 0);
        chk("ldr_done_stall", mem_stall, 0);
        chk("ldr_done_out", mem_rdata_out, 16'hBEEF);
        advance();
        chk("ldr_idle_out", mem_rdata_out, 0);

        // misaligned word load is aligned down
        issue(16'h1005, 16'h0, 1, 0, 0, 0);
        step(); clear_ops(); #1;
        chk("ldr_odd_addr", dmem_addr, 16'h1004);
        respond(16'h1357);
        chk("ldr_odd_out", mem_rdata_out, 16'h1357);
        advance();

        // 2: STB 0x2001, sdata 0x12A5
        issue(16'h2001, 16'h12A5, 0, 1, 1, 0);
        step(); clear_ops(); #1;
        chk("stb_wr", dmem_write, 1);
        chk("stb_rd", dmem_read, 0);
        chk("stb_wdata", dmem_wdata, 16'hA5A5);
        chk("stb_be", dmem_byte_enable, 2'b10);
        chk("stb_addr", dmem_addr, 16'h2001);
        respond(16'hFFFF);
        chk("stb_done_wr", dmem_write, 0);
        chk("stb_done_out", mem_rdata_out, 0);
        advance();

        // STR 0x2003 -> aligned word write, full mask
        issue(16'h2003, 16'h9C31, 0, 1, 0, 0);
        step(); clear_ops(); #1;
        chk("str_wdata", dmem_wdata, 16'h9C31);
        chk("str_be", dmem_byte_enable, 2'b11);
        chk("str_addr", dmem_addr, 16'h2002);
        respond(16'h0);
        advance();

        // 3: LDB low and high lanes
        issue(16'h3000, 16'h0, 1, 0, 1, 0);
        step(); clear_ops(); #1;
        respond(16'h80F7);
        chk("ldb_lo_out", mem_rdata_out, 16'h00F7);
        advance();
        issue(16'h3001, 16'h0, 1, 0, 1, 0);
        step(); clear_ops(); #1;
        chk("ldb_hi_addr", dmem_addr, 16'h3001);
        respond(16'h80F7);
        chk("ldb_hi_out", mem_rdata_out, 16'h0080);
        advance();

        // 4: LDI 0x4002 -> pointer 0x5000 -> 0x0042
        issue(16'h4002, 16'h0, 1, 0, 0, 1);
        chk("ldi_idle_stall", mem_stall, 1);
        step(); clear_ops(); #1;
        chk("ldi_ind_rd", dmem_read, 1);
        chk("ldi_ind_addr", dmem_addr, 16'h4002);
        chk("ldi_ind_stall", mem_stall, 1);
        respond(16'h5000);
        chk("ldi_acc_rd", dmem_read, 1);
        chk("ldi_acc_addr", dmem_addr, 16'h5000);
        chk("ldi_acc_stall", mem_stall, 1);
        respond(16'h0042);
        chk("ldi_done_out", mem_rdata_out, 16'h0042);

        // 5: hold in DONE for 5 cycles, stray resp ignored
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                dmem_rdata = 16'hDEAD; dmem_resp = 1'b1;
            end
            step();
            dmem_resp = 1'b0; dmem_rdata = 16'h0; #1;
            chk("hold_rd", dmem_read, 0);
            chk("hold_wr", dmem_write, 0);
            chk("hold_stall", mem_stall, 0);
            chk("hold_out", mem_rdata_out, 16'h0042);
        end
        advance();
        chk_quiet("post_adv");

        // 6: reset in ACCESS then late resp
        issue(16'h6000, 16'h0, 1, 0, 0, 0);
        step(); clear_ops(); #1;
        chk("rstacc_rd", dmem_read, 1);
        reset = 1;
        step();
        reset = 0; #1;
        chk_quiet("rstacc");
        respond(16'h1234);
        chk_quiet("late_resp");
        step();
        chk_quiet("late_resp2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
